// File: rtl/gnb_pkg.sv
// Shared types and fixed-point helpers for the gnb_seq Gaussian naive Bayes classifier.
package gnb_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StArgmax, StDone} gnb_state_e;

  // Wide enough to hold any intermediate of a W<=16 term without loss.
  localparam int unsigned FxW = 64;
  localparam logic [FxW-1:0] FxOne = 64'd1;
  localparam logic [FxW-1:0] FxOnes = '1;

  function automatic int unsigned acc_width(input int unsigned w, input int unsigned dims);
    return 2 * w + $clog2(dims) + 1;
  endfunction

  // Sign-extend the low w bits of v to FxW bits.
  function automatic logic signed [FxW-1:0] sext(input logic [FxW-1:0] v, input int unsigned w);
    logic [FxW-1:0] hi;
    hi = FxOnes << w;
    if (|(v & (FxOne << (w - 1)))) return signed'(v | hi);
    else return signed'(v & ~hi);
  endfunction

  function automatic logic signed [FxW-1:0] mul_shr(input logic signed [FxW-1:0] a,
                                                    input logic signed [FxW-1:0] b,
                                                    input int unsigned frac);
    return (a * b) >>> frac;
  endfunction

endpackage

// File: rtl/gnb_term.sv
// Combinational term for one (class, dim): ((diff^2 >> FRAC) * sigma >> FRAC) + logsigma.
module gnb_term import gnb_pkg::*; #(
  parameter int unsigned W     = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned ACC_W = 36
) (
  input  logic [W-1:0]     din_i,
  input  logic [W-1:0]     theta_i,
  input  logic [W-1:0]     sigma_i,
  input  logic [W-1:0]     logsigma_i,
  output logic [ACC_W-1:0] term_o
);

  logic [W:0]            diff;
  logic signed [FxW-1:0] diff_x;
  logic signed [FxW-1:0] sq;
  logic signed [FxW-1:0] scaled;
  logic signed [FxW-1:0] term_x;

  always_comb begin
    diff   = {din_i[W-1], din_i} - {theta_i[W-1], theta_i};
    diff_x = sext(FxW'(diff), W + 1);
    sq     = mul_shr(diff_x, diff_x, FRAC);
    scaled = mul_shr(sq, signed'(FxW'(sigma_i)), FRAC);
    term_x = scaled + sext(FxW'(logsigma_i), W);
    term_o = ACC_W'(term_x);
  end

endmodule

// File: rtl/gnb_seq.sv
// Sequential handshaked Gaussian naive Bayes classifier: per-dim accumulate, then serial argmax.
// Optional GNB_MARGIN_EN adds margin_o (best minus runner-up vote).
module gnb_seq import gnb_pkg::*; #(
  parameter int unsigned W       = 16,
  parameter int unsigned FRAC    = 8,
  parameter int unsigned DIMS    = 6,
  parameter int unsigned CLASSES = 4,
  parameter int unsigned ACC_W   = acc_width(W, DIMS)
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [DIMS-1:0][W-1:0]               din_i,
  input  logic [CLASSES-1:0][DIMS-1:0][W-1:0]  theta_i,
  input  logic [CLASSES-1:0][DIMS-1:0][W-1:0]  sigma_i,
  input  logic [CLASSES-1:0][DIMS-1:0][W-1:0]  logsigma_i,
  input  logic [CLASSES-1:0][W-1:0]            beta_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [CLASSES-1:0]                   dout_o,
  output logic [$clog2(CLASSES)-1:0]           class_o
`ifdef GNB_MARGIN_EN
  ,
  output logic [ACC_W-1:0]                     margin_o
`endif
);

  localparam int unsigned ClsW = $clog2(CLASSES);
  localparam int unsigned DimW = (DIMS > 1) ? $clog2(DIMS) : 1;
  localparam int unsigned CntW = (DimW > ClsW) ? DimW : ClsW;
  localparam logic signed [ACC_W-1:0] MinVote = {1'b1, {(ACC_W - 1){1'b0}}};

  gnb_state_e                     state_q, state_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [DIMS-1:0][W-1:0]         din_q, din_d;
  logic [CLASSES-1:0][ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]        best_q, best_d;
  logic [ClsW-1:0]                idx_q, idx_d;
  logic                           in_ready_q, in_ready_d;
  logic                           out_valid_q, out_valid_d;
  logic [CLASSES-1:0]             dout_q, dout_d;
  logic [ClsW-1:0]                class_q, class_d;
`ifdef GNB_MARGIN_EN
  logic signed [ACC_W-1:0]        second_q, second_d;
  logic [ACC_W-1:0]               margin_q, margin_d;
`endif

  logic [CLASSES-1:0][ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]        vote;
  logic [DimW-1:0]                dim;
  logic [ClsW-1:0]                cls;

  // One counter serves as dimension index in ACCUM and class index in ARGMAX.
  assign dim  = cnt_q[DimW-1:0];
  assign cls  = cnt_q[ClsW-1:0];
  assign vote = $signed(ACC_W'($signed(beta_i[cls]))) - $signed(acc_q[cls]);

  for (genvar k = 0; k < CLASSES; k++) begin : g_term
    gnb_term #(
      .W     (W),
      .FRAC  (FRAC),
      .ACC_W (ACC_W)
    ) u_term (
      .din_i      (din_q[dim]),
      .theta_i    (theta_i[k][dim]),
      .sigma_i    (sigma_i[k][dim]),
      .logsigma_i (logsigma_i[k][dim]),
      .term_o     (term[k])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    din_d       = din_q;
    acc_d       = acc_q;
    best_d      = best_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    class_d     = class_q;
`ifdef GNB_MARGIN_EN
    second_d    = second_q;
    margin_d    = margin_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          din_d      = din_i;
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = StAccum;
        end
      end
      StAccum: begin
        for (int k = 0; k < CLASSES; k++) acc_d[k] = acc_q[k] + term[k];
        if (cnt_q == CntW'(DIMS - 1)) begin
          cnt_d   = '0;
          state_d = StArgmax;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StArgmax: begin
        // Strict compare keeps the lowest index on ties.
        if (cnt_q == '0 || vote > best_q) begin
`ifdef GNB_MARGIN_EN
          second_d = (cnt_q == '0) ? MinVote : best_q;
`endif
          best_d = vote;
          idx_d  = cls;
        end
`ifdef GNB_MARGIN_EN
        else if (vote > second_q) begin
          second_d = vote;
        end
`endif
        if (cnt_q == CntW'(CLASSES - 1)) begin
          cnt_d       = '0;
          state_d     = StDone;
          out_valid_d = 1'b1;
          dout_d      = CLASSES'(1) << idx_d;
          class_d     = idx_d;
`ifdef GNB_MARGIN_EN
          margin_d    = best_d - second_d;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d     = StIdle;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          dout_d      = '0;
          class_d     = '0;
`ifdef GNB_MARGIN_EN
          margin_d    = '0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      din_q       <= '0;
      acc_q       <= '0;
      best_q      <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      class_q     <= '0;
`ifdef GNB_MARGIN_EN
      second_q    <= '0;
      margin_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      din_q       <= din_d;
      acc_q       <= acc_d;
      best_q      <= best_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      class_q     <= class_d;
`ifdef GNB_MARGIN_EN
      second_q    <= second_d;
      margin_q    <= margin_d;
`endif
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign dout_o      = dout_q;
  assign class_o     = class_q;
`ifdef GNB_MARGIN_EN
  assign margin_o    = margin_q;
`endif

endmodule

// File: tb/tb_gnb_seq.sv
// Randomised self-checking bench for gnb_seq against a plain-arithmetic Bayes vote model.
module tb_gnb_seq;

  localparam int unsigned W       = 16;
  localparam int unsigned FRAC    = 8;
  localparam int unsigned DIMS    = 6;
  localparam int unsigned CLASSES = 4;
  localparam int unsigned ACC_W   = 2 * W + $clog2(DIMS) + 1;
  localparam longint      Scale   = 256;

  logic                                clk;
  logic                                rstn;
  logic                                in_valid;
  logic                                in_ready;
  logic [DIMS-1:0][W-1:0]              din;
  logic [CLASSES-1:0][DIMS-1:0][W-1:0] theta;
  logic [CLASSES-1:0][DIMS-1:0][W-1:0] sigma;
  logic [CLASSES-1:0][DIMS-1:0][W-1:0] logsigma;
  logic [CLASSES-1:0][W-1:0]           beta;
  logic                                out_valid;
  logic                                out_ready;
  logic [CLASSES-1:0]                  dout;
  logic [$clog2(CLASSES)-1:0]          cls;
`ifdef GNB_MARGIN_EN
  logic [ACC_W-1:0]                    margin;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  gnb_seq #(
    .W       (W),
    .FRAC    (FRAC),
    .DIMS    (DIMS),
    .CLASSES (CLASSES),
    .ACC_W   (ACC_W)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .din_i       (din),
    .theta_i     (theta),
    .sigma_i     (sigma),
    .logsigma_i  (logsigma),
    .beta_i      (beta),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .dout_o      (dout),
    .class_o     (cls)
`ifdef GNB_MARGIN_EN
    ,
    .margin_o    (margin)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", tag, got, exp);
  endtask

  // Reference: vote[k] = beta[k] - sum_d (floor(floor(diff^2/2^F) * sigma / 2^F) + logsigma).
  task automatic model(output int exp_cls, output longint exp_margin);
    longint vote [CLASSES];
    longint acc, diff, sq, best, second;
    for (int k = 0; k < CLASSES; k++) begin
      acc = 0;
      for (int d = 0; d < DIMS; d++) begin
        diff = longint'($signed(din[d])) - longint'($signed(theta[k][d]));
        sq   = (diff * diff) / Scale;
        acc += (sq * longint'(sigma[k][d])) / Scale + longint'($signed(logsigma[k][d]));
      end
      vote[k] = longint'($signed(beta[k])) - acc;
    end
    exp_cls = 0;
    best    = vote[0];
    for (int k = 1; k < CLASSES; k++) begin
      if (vote[k] > best) begin
        best    = vote[k];
        exp_cls = k;
      end
    end
    second = -(longint'(1) << 62);
    for (int k = 0; k < CLASSES; k++) begin
      if (k != exp_cls && vote[k] > second) second = vote[k];
    end
    exp_margin = best - second;
  endtask

  task automatic rand_inputs();
    for (int d = 0; d < DIMS; d++) din[d] = W'($urandom);
    for (int k = 0; k < CLASSES; k++) begin
      beta[k] = W'($urandom);
      for (int d = 0; d < DIMS; d++) begin
        theta[k][d]    = W'($urandom);
        sigma[k][d]    = W'($urandom);
        logsigma[k][d] = W'($urandom);
      end
    end
  endtask

  // Accept one vector, check latency/result, optionally stall in DONE, then hand off.
  task automatic run_vec(input string tag, input int hold);
    int     exp_cls;
    longint exp_margin;
    int     lat;
    model(exp_cls, exp_margin);
    check({tag, ".in_ready"}, longint'(in_ready), 1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, lat, DIMS + CLASSES);
    check({tag, ".class"}, longint'(cls), exp_cls);
    check({tag, ".dout"}, longint'(dout), longint'(1) << exp_cls);
`ifdef GNB_MARGIN_EN
    check({tag, ".margin"}, longint'(margin), exp_margin);
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, longint'(out_valid), 1);
      check({tag, ".hold_dout"}, longint'(dout), longint'(1) << exp_cls);
      check({tag, ".hold_ready"}, longint'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, longint'(out_valid), 0);
    check({tag, ".post_ready"}, longint'(in_ready), 1);
    check({tag, ".post_dout"}, longint'(dout), 0);
  endtask

  initial begin
    int lat;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    theta     = '0;
    sigma     = '0;
    logsigma  = '0;
    beta      = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("reset.in_ready", longint'(in_ready), 1);
    check("reset.out_valid", longint'(out_valid), 0);
    check("reset.dout", longint'(dout), 0);
    check("reset.class", longint'(cls), 0);

    // Zero terms: the prior alone decides.
    for (int d = 0; d < DIMS; d++) din[d] = W'($urandom);
    for (int k = 0; k < CLASSES; k++) begin
      for (int d = 0; d < DIMS; d++) begin
        theta[k][d]    = din[d];
        sigma[k][d]    = 16'h0100;
        logsigma[k][d] = '0;
      end
    end
    beta[0] = 16'd10;
    beta[1] = 16'd50;
    beta[2] = 16'd30;
    beta[3] = 16'd20;
    run_vec("prior", 0);

    // Single active dimension with known term 0x0410.
    din      = '0;
    theta    = '0;
    logsigma = '0;
    for (int k = 0; k < CLASSES; k++) begin
      theta[k][0]    = 16'h0100;
      logsigma[k][0] = 16'h0010;
      beta[k]        = '0;
    end
    din[0]  = 16'h0300;
    beta[0] = 16'h1000;
    run_vec("term", 0);

    // Identical classes: tie goes to index 0.
    rand_inputs();
    for (int k = 1; k < CLASSES; k++) begin
      theta[k]    = theta[0];
      sigma[k]    = sigma[0];
      logsigma[k] = logsigma[0];
      beta[k]     = beta[0];
    end
    run_vec("tie", 0);

    rand_inputs();
    run_vec("stall", 5);

    // Reset during the third ACCUM cycle discards the partial result.
    rand_inputs();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("rst_accum.out_valid", longint'(out_valid), 0);
    check("rst_accum.dout", longint'(dout), 0);
    check("rst_accum.class", longint'(cls), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rst_accum.in_ready", longint'(in_ready), 1);
    rand_inputs();
    run_vec("after_rst", 0);

    // Reset while holding a result in DONE.
    rand_inputs();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rst_done.reached", longint'(out_valid), 1);
    rstn = 1'b0;
    #1;
    check("rst_done.out_valid", longint'(out_valid), 0);
    check("rst_done.dout", longint'(dout), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      rand_inputs();
      run_vec($sformatf("rand%0d", i), i % 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
